// File: rtl/tc_timer_if.sv
// Bus bundle between the system bridge and the tc_timer register block.
// Latency: none; a pure wire bundle.
// Backpressure: none; the bridge issues one access per cycle, always accepted.
//
// Signals:
//   addr - byte address from the bridge (only addr[3:2] is decoded by the timer)
//   we   - write enable, already qualified by the bridge chip-select
//   din  - write data
//   dout - combinational read data returned to the bridge
interface tc_timer_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;

    // Bridge side drives the request and samples the read data.
    modport master (
        output addr,
        output we,
        output din,
        input  dout
    );

    // Timer side decodes the request and returns the read data.
    modport slave (
        input  addr,
        input  we,
        input  din,
        output dout
    );
endinterface : tc_timer_if

// File: rtl/tc_timer.sv
// Memory-mapped 32-bit down-counting timer; drives CP0 hwInt[0].
// Latency: reads combinational; irq rises preset+2 edges after the enabling CTRL write.
// Backpressure: none; every bus write is accepted at the clock edge it is presented on.
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - asynchronous active-low reset, clears all state immediately
//   bus   - bridge access (addr/we/din in, dout out), slave modport
//   irq   - interrupt request, intFlag gated by CTRL.IM
//
// Register map (addr[3:2]):
//   0 CTRL   : bit0 EN, bits2:1 MODE (1 = auto-reload, else one-shot), bit3 IM
//   1 PRESET : reload value, R/W
//   2 COUNT  : current count, read-only
//   3        : reads 0, writes ignored
module tc_timer (
    input  logic      clk,
    input  logic      reset,
    tc_timer_if.slave bus,
    output logic      irq
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Register select values on addr[3:2]
    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;

    localparam logic [1:0] MODE_RELOAD = 2'd1;

    logic [3:0]  ctrl_q,     ctrl_d;
    logic [31:0] preset_q,   preset_d;
    logic [31:0] count_q,    count_d;
    logic [1:0]  state_q,    state_d;
    logic        int_flag_q, int_flag_d;

    logic [1:0] reg_sel;
    logic       wr_ctrl;
    logic       wr_preset;
    logic       ctrl_en;
    logic       ctrl_im;
    logic       mode_reload;
    logic       addr_unused;

    assign reg_sel     = bus.addr[3:2];
    assign wr_ctrl     = bus.we && (reg_sel == SEL_CTRL);
    assign wr_preset   = bus.we && (reg_sel == SEL_PRESET);
    assign ctrl_en     = ctrl_q[0];
    assign ctrl_im     = ctrl_q[3];
    // MODE 2 and 3 fall back to one-shot behaviour.
    assign mode_reload = (ctrl_q[2:1] == MODE_RELOAD);

    // Only addr[3:2] participates in the decode.
    assign addr_unused = ^{bus.addr[31:4], bus.addr[1:0]};

    // ------------------------------------------------------------------
    // Next-state logic: FSM first, bus writes applied last so that a CPU
    // write always wins over the FSM for CTRL bits and intFlag.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        state_d    = state_q;
        int_flag_d = int_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_en) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end

            ST_CNT: begin
                if (!ctrl_en) begin
                    // Pause: count holds where it stopped.
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Terminal count; 0 is treated like 1 so there is no wrap.
                    count_d    = 32'd0;
                    int_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end

            ST_INT: begin
                state_d = ST_IDLE;
                if (mode_reload) begin
                    // Single-cycle pulse; EN stays set so the next period reloads.
                    int_flag_d = 1'b0;
                end else begin
                    // One-shot: stop, keep the level interrupt until software acks.
                    ctrl_d[0] = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_ctrl) begin
            ctrl_d     = bus.din[3:0];
            int_flag_d = 1'b0;
        end

        // A PRESET write never touches count; it is picked up at the next LOAD.
        if (wr_preset) begin
            preset_d   = bus.din;
            int_flag_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            state_q    <= ST_IDLE;
            int_flag_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            state_q    <= state_d;
            int_flag_q <= int_flag_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux: purely combinational, no read side effects.
    // ------------------------------------------------------------------
    always_comb begin
        case (reg_sel)
            SEL_CTRL:   bus.dout = {28'd0, ctrl_q};
            SEL_PRESET: bus.dout = preset_q;
            SEL_COUNT:  bus.dout = count_q;
            default:    bus.dout = 32'd0;
        endcase
    end

    // Driven from flops only, so bus activity cannot glitch the interrupt line.
    assign irq = int_flag_q & ctrl_im;

endmodule : tc_timer

// File: tb/tb_tc_timer.sv
// Testbench for tc_timer: directed scenarios plus randomized runs against a
// closed-form timing model (count and irq as functions of cycles since start).
module tb_tc_timer;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_PRESET = 32'h4;
    localparam logic [31:0] A_COUNT  = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    logic clk;
    logic rst_n;
    logic irq;
    int   checks;
    int   errors;

    tc_timer_if bus ();

    tc_timer dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave),
        .irq   (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a write on the falling edge; it takes effect at the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.dout;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] got;
        logic [31:0] addrs [4];
        addrs = '{A_CTRL, A_PRESET, A_COUNT, A_RSVD};
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        foreach (addrs[i]) begin
            rd(addrs[i], got);
            checks++;
            if (got !== 32'd0) begin
                errors++;
                $display("FAIL reset_read addr=%0h: got %0h expected 0", addrs[i], got);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %0b expected 0", irq);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_one_shot();
        logic [31:0] got;
        do_reset();
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_early: got %0b expected 0", irq);
        end
        for (int k = 0; k <= 5; k++) begin
            step();
            rd(A_COUNT, got);
            checks++;
            if (got !== 32'(5 - k)) begin
                errors++;
                $display("FAIL oneshot_count k=%0d: got %0d expected %0d", k, got, 5 - k);
            end
            checks++;
            if (irq !== (k == 5)) begin
                errors++;
                $display("FAIL oneshot_irq k=%0d: got %0b expected %0b", k, irq, (k == 5));
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (irq !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_irq_hold k=%0d: got %0b expected 1", k, irq);
            end
        end
        rd(A_CTRL, got);
        checks++;
        if (got !== 32'h8) begin
            errors++;
            $display("FAIL oneshot_ctrl: got %0h expected 8", got);
        end
        wr(A_CTRL, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_ack: got %0b expected 0", irq);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_periodic();
        logic [31:0] got;
        int          pulses;
        logic        exp_irq;
        pulses = 0;
        do_reset();
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'hB);
        step();
        step();
        // s counts edges since the first LOAD; pulses at s = 5, 13, 21, 29.
        for (int s = 0; s < 36; s++) begin
            exp_irq = (s >= 5) && (((s - 5) % 8) == 0);
            checks++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL periodic_irq s=%0d: got %0b expected %0b", s, irq, exp_irq);
            end
            if (irq === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses < 4) begin
            errors++;
            $display("FAIL periodic_pulses: got %0d expected >=4", pulses);
        end
        rd(A_CTRL, got);
        checks++;
        if (got !== 32'hB) begin
            errors++;
            $display("FAIL periodic_ctrl: got %0h expected b", got);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_masking();
        logic [31:0] got;
        do_reset();
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'h1);
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL mask_irq k=%0d: got %0b expected 0", k, irq);
            end
        end
        rd(A_COUNT, got);
        checks++;
        if (got !== 32'd0) begin
            errors++;
            $display("FAIL mask_count: got %0d expected 0", got);
        end
        rd(A_CTRL, got);
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL mask_ctrl: got %0h expected 0", got);
        end
        wr(A_CTRL, 32'h8);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL mask_unmask k=%0d: got %0b expected 0", k, irq);
            end
            step();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pause_collision();
        logic [31:0] got;
        do_reset();
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        step();
        step();
        step();
        // COUNT reads 4 now; the write lands on the edge where it becomes 3.
        wr(A_CTRL, 32'h8);
        for (int k = 0; k < 5; k++) begin
            rd(A_COUNT, got);
            checks++;
            if (got !== 32'd3) begin
                errors++;
                $display("FAIL pause_count k=%0d: got %0d expected 3", k, got);
            end
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL pause_irq k=%0d: got %0b expected 0", k, irq);
            end
            step();
        end
        // Re-enable: a fresh LOAD of 5 proves the FSM parked in IDLE.
        wr(A_CTRL, 32'h9);
        step();
        step();
        rd(A_COUNT, got);
        checks++;
        if (got !== 32'd5) begin
            errors++;
            $display("FAIL pause_reload: got %0d expected 5", got);
        end
        for (int k = 0; k < 5; k++) step();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL collide_pre_irq: got %0b expected 1", irq);
        end
        // FSM sits in INT this cycle; the CPU write must win over the EN clear.
        wr(A_CTRL, 32'h9);
        rd(A_CTRL, got);
        checks++;
        if (got !== 32'h9) begin
            errors++;
            $display("FAIL collide_ctrl: got %0h expected 9", got);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL collide_irq: got %0b expected 0", irq);
        end
        step();
        step();
        rd(A_COUNT, got);
        checks++;
        if (got !== 32'd5) begin
            errors++;
            $display("FAIL collide_restart: got %0d expected 5", got);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_preset_during_cnt();
        logic [31:0] got;
        do_reset();
        wr(A_PRESET, 32'd6);
        wr(A_CTRL, 32'h9);
        step();
        step();
        step();
        wr(A_PRESET, 32'd3);
        rd(A_COUNT, got);
        checks++;
        if (got !== 32'd4) begin
            errors++;
            $display("FAIL preset_cnt_unaffected: got %0d expected 4", got);
        end
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL preset_cnt_irq: got %0b expected 1", irq);
        end
        wr(A_CTRL, 32'h9);
        step();
        step();
        rd(A_COUNT, got);
        checks++;
        if (got !== 32'd3) begin
            errors++;
            $display("FAIL preset_next_load: got %0d expected 3", got);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        logic [31:0] got;
        logic [31:0] addrs [4];
        addrs = '{A_CTRL, A_PRESET, A_COUNT, A_RSVD};
        do_reset();
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h9);
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_irq: got %0b expected 1", irq);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL areset_irq: got %0b expected 0", irq);
        end
        foreach (addrs[i]) begin
            rd(addrs[i], got);
            checks++;
            if (got !== 32'd0) begin
                errors++;
                $display("FAIL areset_read addr=%0h: got %0h expected 0", addrs[i], got);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // ------------------------------------------------------------------
    // Randomized runs. Model: with s = edges since the first LOAD edge,
    // eff = max(P,1), L = eff+3:
    //   one-shot: count = s<=P ? P-s : 0, irq = IM && s>=eff, EN clears at s>=eff+1
    //   reload  : r = s mod L, count = r<=P ? P-r : 0, irq = IM && r==eff
    task automatic test_random();
        int unsigned p;
        int unsigned eff;
        int unsigned len;
        int unsigned r;
        logic [1:0]  mode;
        logic        im;
        logic        periodic;
        logic [31:0] got;
        logic [31:0] exp_cnt;
        logic [31:0] exp_ctrl;
        logic        exp_irq;
        for (int trial = 0; trial < 10; trial++) begin
            p        = $urandom_range(0, 10);
            mode     = 2'($urandom_range(0, 3));
            im       = 1'($urandom_range(0, 1));
            eff      = (p == 0) ? 1 : p;
            len      = eff + 3;
            periodic = (mode == 2'd1);
            do_reset();
            wr(A_PRESET, p);
            wr(A_CTRL, {28'd0, im, mode, 1'b1});
            step();
            step();
            for (int unsigned s = 0; s < 3 * len; s++) begin
                r        = periodic ? (s % len) : s;
                exp_cnt  = (r <= p) ? (p - r) : 32'd0;
                exp_irq  = im && (periodic ? (r == eff) : (s >= eff));
                exp_ctrl = (!periodic && s >= eff + 1) ? {28'd0, im, mode, 1'b0}
                                                       : {28'd0, im, mode, 1'b1};
                rd(A_COUNT, got);
                checks++;
                if (got !== exp_cnt) begin
                    errors++;
                    $display("FAIL rand_count t=%0d P=%0d mode=%0d s=%0d: got %0d expected %0d",
                             trial, p, mode, s, got, exp_cnt);
                end
                checks++;
                if (irq !== exp_irq) begin
                    errors++;
                    $display("FAIL rand_irq t=%0d P=%0d mode=%0d im=%0b s=%0d: got %0b expected %0b",
                             trial, p, mode, im, s, irq, exp_irq);
                end
                rd(A_CTRL, got);
                checks++;
                if (got !== exp_ctrl) begin
                    errors++;
                    $display("FAIL rand_ctrl t=%0d P=%0d mode=%0d s=%0d: got %0h expected %0h",
                             trial, p, mode, s, got, exp_ctrl);
                end
                step();
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.addr = 32'd0;
        bus.we   = 1'b0;
        bus.din  = 32'd0;

        test_reset();
        test_one_shot();
        test_periodic();
        test_masking();
        test_pause_collision();
        test_preset_during_cnt();
        test_async_reset();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tc_timer
